// File: rtl/adder_result_buffer_if.sv
// Bus between the ALSU adder stage, the result buffer and its downstream consumer.
// Both sides follow valid/ready: a beat transfers on a rising edge where valid && ready.
interface adder_result_buffer_if #(
   parameter int Width     = 4,
   parameter int Width_Sel = 5,
   parameter int Depth     = 4
);
   localparam int CountW = $clog2(Depth) + 1;

   logic                 in_valid;
   logic                 in_ready;
   logic [Width_Sel-1:0] Sel;
   logic [Width-1:0]     Sum;
   logic                 carry_out;
   logic                 Negative_Sign_Adder_Flag;

   logic                 out_valid;
   logic                 out_ready;
   logic [Width_Sel-1:0] out_sel;
   logic [Width-1:0]     out_sum;
   logic                 out_carry;
   logic                 out_neg;
   logic                 out_zero;
   logic [CountW-1:0]    count;

   logic                 clear_flags;
   logic                 carry_seen;
   logic                 neg_seen;
   logic [3:0]           drop_count;

   modport slave (
      input  in_valid, Sel, Sum, carry_out, Negative_Sign_Adder_Flag,
      input  out_ready, clear_flags,
      output in_ready, out_valid, out_sel, out_sum, out_carry, out_neg, out_zero,
      output count, carry_seen, neg_seen, drop_count
   );

   modport master (
      output in_valid, Sel, Sum, carry_out, Negative_Sign_Adder_Flag,
      output out_ready, clear_flags,
      input  in_ready, out_valid, out_sel, out_sum, out_carry, out_neg, out_zero,
      input  count, carry_seen, neg_seen, drop_count
   );
endinterface

// File: rtl/adder_result_buffer.sv
// Show-ahead FIFO capturing adder results with a zero tag, sticky carry/negative
// status and a saturating count of results offered while full.
module adder_result_buffer #(
   parameter int Width     = 4,
   parameter int Width_Sel = 5,
   parameter int Depth     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   adder_result_buffer_if.slave bus
);
   localparam int PtrW   = $clog2(Depth);
   localparam int CountW = PtrW + 1;
   localparam int EntryW = Width_Sel + Width + 3;

   logic [EntryW-1:0] mem [Depth];
   logic [PtrW-1:0]   wr_ptr;
   logic [PtrW-1:0]   rd_ptr;
   logic [CountW-1:0] count_q;
   logic              carry_q;
   logic              neg_q;
   logic [3:0]        drop_q;

   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              drop;
   logic              sum_zero;
   logic [EntryW-1:0] head;

   assign full     = (count_q == CountW'(Depth));
   assign empty    = (count_q == '0);
   assign push     = bus.in_valid && !full;
   assign pop      = bus.out_ready && !empty;
   assign drop     = bus.in_valid && full;
   assign sum_zero = (bus.Sum == '0);

   // Storage needs no reset: empty occupancy masks stale entries at the output.
   always_ff @(posedge clk) begin
      if (!rst && push)
         mem[wr_ptr] <= {bus.Sel, bus.Sum, bus.carry_out, bus.Negative_Sign_Adder_Flag, sum_zero};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         carry_q <= 1'b0;
         neg_q   <= 1'b0;
         drop_q  <= 4'd0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count_q <= count_q + 1'b1;
         else if (pop && !push)
            count_q <= count_q - 1'b1;

         // A same-cycle event overrides clear_flags.
         carry_q <= (carry_q && !bus.clear_flags) || (push && bus.carry_out);
         neg_q   <= (neg_q && !bus.clear_flags) || (push && bus.Negative_Sign_Adder_Flag);
         if (drop) begin
            if (bus.clear_flags)
               drop_q <= 4'd1;
            else if (drop_q != 4'd15)
               drop_q <= drop_q + 4'd1;
         end else if (bus.clear_flags) begin
            drop_q <= 4'd0;
         end
      end
   end

   assign head = empty ? '0 : mem[rd_ptr];

   assign bus.in_ready   = !full;
   assign bus.out_valid  = !empty;
   assign bus.out_sel    = head[EntryW-1 -: Width_Sel];
   assign bus.out_sum    = head[Width+2 -: Width];
   assign bus.out_carry  = head[2];
   assign bus.out_neg    = head[1];
   assign bus.out_zero   = head[0];
   assign bus.count      = count_q;
   assign bus.carry_seen = carry_q;
   assign bus.neg_seen   = neg_q;
   assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_adder_result_buffer.sv
// Directed bench for adder_result_buffer with immediate-assertion checks.
module tb_adder_result_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   adder_result_buffer_if #(.Width(4), .Width_Sel(5), .Depth(4)) bus ();

   adder_result_buffer #(.Width(4), .Width_Sel(5), .Depth(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic v, input logic [4:0] sel, input logic [3:0] sum,
                         input logic c, input logic n);
      bus.in_valid                 = v;
      bus.Sel                      = sel;
      bus.Sum                      = sum;
      bus.carry_out                = c;
      bus.Negative_Sign_Adder_Flag = n;
   endtask

   initial begin
      set_in(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
      bus.out_ready   = 1'b0;
      bus.clear_flags = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_count", bus.count, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_sum", bus.out_sum, 0);
      check("rst_carry_seen", bus.carry_seen, 0);
      check("rst_neg_seen", bus.neg_seen, 0);
      check("rst_drop", bus.drop_count, 0);

      // Single push F+3 = carry 1, sum 2
      set_in(1'b1, 5'd0, 4'd2, 1'b1, 1'b0);
      tick();
      set_in(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
      check("one_out_valid", bus.out_valid, 1);
      check("one_out_sum", bus.out_sum, 2);
      check("one_out_carry", bus.out_carry, 1);
      check("one_out_zero", bus.out_zero, 0);
      check("one_carry_seen", bus.carry_seen, 1);
      check("one_count", bus.count, 1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("pop_out_valid", bus.out_valid, 0);
      check("pop_count", bus.count, 0);
      check("pop_out_sum", bus.out_sum, 0);
      check("pop_out_carry", bus.out_carry, 0);

      // Fill to full, then two offers are dropped
      for (int i = 1; i <= 4; i++) begin
         set_in(1'b1, 5'd2, 4'(i), 1'b0, 1'b0);
         tick();
      end
      check("full_count", bus.count, 4);
      check("full_in_ready", bus.in_ready, 0);
      set_in(1'b1, 5'd2, 4'd9, 1'b0, 1'b0);
      tick();
      tick();
      set_in(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
      check("full_drop", bus.drop_count, 2);
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check($sformatf("drain_sum_%0d", i), bus.out_sum, i);
         tick();
      end
      bus.out_ready = 1'b0;
      check("drain_count", bus.count, 0);

      // Clear, then streaming push+pop at count=2 across pointer wrap
      bus.clear_flags = 1'b1;
      tick();
      bus.clear_flags = 1'b0;
      check("clr_drop", bus.drop_count, 0);
      check("clr_carry_seen", bus.carry_seen, 0);
      set_in(1'b1, 5'd3, 4'd10, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 5'd3, 4'd11, 1'b0, 1'b0);
      tick();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         check($sformatf("stream_head_%0d", k), bus.out_sum, (10 + k) % 16);
         set_in(1'b1, 5'd3, 4'((12 + k) % 16), 1'b0, 1'b0);
         tick();
         check($sformatf("stream_count_%0d", k), bus.count, 2);
      end
      set_in(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
      check("stream_drop", bus.drop_count, 0);
      check("stream_tail0_sum", bus.out_sum, 0);
      check("stream_tail0_zero", bus.out_zero, 1);
      tick();
      check("stream_tail1_sum", bus.out_sum, 1);
      tick();
      bus.out_ready = 1'b0;
      check("stream_empty", bus.count, 0);

      // Full with pop and offer in the same cycle: no push, one drop
      for (int i = 5; i <= 8; i++) begin
         set_in(1'b1, 5'd4, 4'(i), 1'b0, 1'b0);
         tick();
      end
      set_in(1'b1, 5'd4, 4'd9, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      tick();
      set_in(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      check("fullpop_drop", bus.drop_count, 1);
      check("fullpop_count", bus.count, 3);
      check("fullpop_in_ready", bus.in_ready, 1);
      bus.out_ready = 1'b1;
      for (int i = 6; i <= 8; i++) begin
         check($sformatf("fullpop_drain_%0d", i), bus.out_sum, i);
         tick();
      end
      bus.out_ready = 1'b0;
      check("fullpop_empty", bus.out_valid, 0);

      // Negative push wins over a same-cycle clear; zero result is tagged
      bus.clear_flags = 1'b1;
      set_in(1'b1, 5'd1, 4'd2, 1'b0, 1'b1);
      tick();
      bus.clear_flags = 1'b0;
      set_in(1'b1, 5'd1, 4'd0, 1'b0, 1'b0);
      tick();
      set_in(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
      check("neg_seen_after_clear", bus.neg_seen, 1);
      check("neg_clr_drop", bus.drop_count, 0);
      check("neg_head_sel", bus.out_sel, 1);
      check("neg_head_neg", bus.out_neg, 1);
      check("neg_head_sum", bus.out_sum, 2);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("zero_head_valid", bus.out_valid, 1);
      check("zero_head_sum", bus.out_sum, 0);
      check("zero_head_zero", bus.out_zero, 1);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      bus.clear_flags = 1'b1;
      tick();
      bus.clear_flags = 1'b0;
      check("clr2_neg_seen", bus.neg_seen, 0);
      check("clr2_carry_seen", bus.carry_seen, 0);
      check("clr2_drop", bus.drop_count, 0);

      // Reset with 3 entries and flags set; push on the reset cycle is lost
      for (int i = 3; i <= 5; i++) begin
         set_in(1'b1, 5'd6, 4'(i), 1'b1, 1'b1);
         tick();
      end
      check("pre_rst_count", bus.count, 3);
      check("pre_rst_carry_seen", bus.carry_seen, 1);
      rst = 1'b1;
      set_in(1'b1, 5'd6, 4'd7, 1'b1, 1'b1);
      tick();
      rst = 1'b0;
      set_in(1'b0, 5'd0, 4'd0, 1'b0, 1'b0);
      check("mid_rst_count", bus.count, 0);
      check("mid_rst_out_valid", bus.out_valid, 0);
      check("mid_rst_out_sum", bus.out_sum, 0);
      check("mid_rst_in_ready", bus.in_ready, 1);
      check("mid_rst_carry_seen", bus.carry_seen, 0);
      check("mid_rst_neg_seen", bus.neg_seen, 0);
      check("mid_rst_drop", bus.drop_count, 0);
      tick();
      check("post_rst_count", bus.count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/adder_result_buffer.md
# adder_result_buffer

Registered result buffer directly downstream of the 4-bit adder stage (`Adder_TOP_Module`) of the ALSU. It captures each adder result (`Sum`, `carry_out`, `Negative_Sign_Adder_Flag`) with its `Sel` code into a show-ahead FIFO under a valid/ready handshake. It tags each entry with a zero flag and keeps sticky carry/negative status plus a saturating drop counter for results offered while full. Consumers (display/serial stages) drain it at their own rate.

## Interface
- `Width`, 4, operand/result width; matches the adder `Sum`.
- `Width_Sel`, 5, select-code width; matches the adder `Sel`.
- `Depth`, 4, FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  adder result presented this cycle.
- `in_ready`  out  1  buffer can accept; `!full`, combinational from occupancy.
- `Sel`  in  `Width_Sel`  select code applied to the adder for this result.
- `Sum`  in  `Width`  adder result.
- `carry_out`  in  1  adder carry.
- `Negative_Sign_Adder_Flag`  in  1  adder negative flag (A-B with B>A).
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  consumer pops head when `out_valid` is high.
- `out_sel`  out  `Width_Sel`  head select code.
- `out_sum`  out  `Width`  head result.
- `out_carry`  out  1  head carry.
- `out_neg`  out  1  head negative flag.
- `out_zero`  out  1  head result was 0 at capture.
- `count`  out  clog2(`Depth`)+1  current occupancy.
- `clear_flags`  in  1  synchronous clear of sticky flags and drop counter.
- `carry_seen`  out  1  sticky: some accepted entry had carry=1.
- `neg_seen`  out  1  sticky: some accepted entry had negative=1.
- `drop_count`  out  4  results offered while full; saturates at 15.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes {`Sel`, `Sum`, `carry_out`, `Negative_Sign_Adder_Flag`, `Sum==0`} at the write pointer. The write pointer increments modulo `Depth`.
- Pop: `out_valid && out_ready` at a rising edge advances the read pointer modulo `Depth`.
- Occupancy: push only → `count+1`; pop only → `count-1`; both → unchanged.
- Full (`count==Depth`): `in_ready=0`. No push occurs even if a pop happens in the same cycle; `in_ready` rises the cycle after the pop.
- Empty (`count==0`): `out_valid=0`. All `out_*` data outputs read 0, and `out_ready` is ignored.
- Show-ahead: `out_*` always reflect the head entry while `out_valid=1`. No read latency.
- Drop: `in_valid && !in_ready` → `drop_count` increments, saturating at 15. The data is discarded.
- Sticky flags: set on push when the captured carry or negative bit is 1. `clear_flags` zeroes `carry_seen`, `neg_seen` and `drop_count`. If a set or drop event occurs in the same cycle as `clear_flags`, the event wins: the flag ends at 1 and `drop_count` at 1.
- `Sel` is captured verbatim, with no decoding. `out_zero` is evaluated on the captured `Sum` only; carry is ignored, so F+1 gives `out_zero=1`, `out_carry=1`.

## Timing
- Reset values: `count=0`, `out_valid=0`, all `out_*` data 0, `in_ready=1`, `carry_seen=0`, `neg_seen=0`, `drop_count=0`. Read and write pointers are 0.
- Reset mid-operation empties the buffer at that edge. Entries are lost; input and output handshakes on the reset cycle are ignored.
- Latency: data pushed at edge N is visible with `out_valid=1` after edge N, so one cycle from `in_valid` to `out_valid`.
- Throughput: one push and one pop per cycle sustained when not full.
- Pointer wrap: after `Depth` pushes the write pointer returns to 0. Ordering is strict FIFO across the wrap.
- `count`, `out_*`, sticky flags and `drop_count` are registered or driven from registered state. `in_ready` and `out_valid` depend only on `count`, not on same-cycle inputs.

## Test plan
- Reset then single push: `Sel=00`, `Sum=0010`, carry=1, neg=0 (F+3). → Next cycle `out_valid=1`, `out_sum=0010`, `out_carry=1`, `out_zero=0`, `carry_seen=1`, `count=1`. Pop → `out_valid=0`, `count=0`, `out_*`=0.
- Fill to full with 4 pushes (Sums 1,2,3,4), `out_ready=0`. → `count=4`, `in_ready=0`. Two more offers → `drop_count=2`. Drain → outputs 1,2,3,4 in order.
- Simultaneous push and pop at `count=2` for 6 cycles with incrementing Sums. → `count` stays 2, ordering preserved across pointer wrap, `drop_count=0`.
- Full with a pop and `in_valid` in the same cycle. → No push that cycle, `drop_count+1`. Next cycle `in_ready=1`, `count=3`.
- Push `Sel=01`, `Sum=0010`, neg=1 (3−5) and `Sum=0000` (0−0) while `clear_flags=1` on the first push. → `neg_seen=1` after the clear cycle, and the second entry reads `out_zero=1`. A later `clear_flags` alone → `neg_seen=0`, `carry_seen=0`, `drop_count=0`.
- Assert `rst` with 3 entries and sticky flags set. → Next cycle all reset values are restored, and a push on the reset cycle is not stored.
